mem_arbiter: RTL and testbench

Shares a single unified main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. Each requester asks for a line-sized burst, receives a one-cycle grant, streams its beats through the shared port, and gets a done pulse on the last beat. The block sits below the fetch and memory stages' caches, in front of main memory, so cache-miss stalls in both pipeline stages resolve through one scheduled resource.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int unsigned BEAT_BYTES = 4;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache refills
// and D-cache refills/write-backs, one line-sized burst at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic                  ic_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_gnt,
  output logic                  dc_wready,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LINE_BYTES = BURST_LEN * BEAT_BYTES;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BURST_LEN - 1);

  arb_state_t            state, state_d;
  arb_owner_t            owner, last_owner, sel_owner;
  logic                  is_write;
  logic                  first;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_W-1:0]      cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_d;
  end

  // Burst context: owner, direction, aligned base, beat counter, grant flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_I;
      last_owner <= OWN_I;
      is_write   <= 1'b0;
      base       <= '0;
      cnt        <= '0;
      first      <= 1'b0;
    end else begin
      first <= start;
      if (start) begin
        owner      <= sel_owner;
        last_owner <= sel_owner;
        is_write   <= (sel_owner == OWN_D) && dc_we;
        base       <= ((sel_owner == OWN_D) ? dc_addr : ic_addr) & LINE_MASK;
        cnt        <= '0;
      end else if (state == ARB_BURST && mem_ready) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Arbitration, next state and port outputs.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    sel_owner = OWN_I;
    ic_gnt    = 1'b0;
    ic_rvalid = 1'b0;
    ic_rdata  = mem_rdata;
    ic_done   = 1'b0;
    dc_gnt    = 1'b0;
    dc_wready = 1'b0;
    dc_rvalid = 1'b0;
    dc_rdata  = mem_rdata;
    dc_done   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      ARB_IDLE: begin
        if (ic_req && dc_req) sel_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        else if (dc_req)      sel_owner = OWN_D;
        else                  sel_owner = OWN_I;
        if (ic_req || dc_req) begin
          start   = 1'b1;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        mem_req   = 1'b1;
        mem_we    = is_write;
        mem_addr  = base + (ADDR_WIDTH'(cnt) << BEAT_SHIFT);
        mem_wdata = dc_wdata;
        if (owner == OWN_I) begin
          ic_gnt    = first;
          ic_rvalid = mem_ready && !is_write;
          ic_done   = mem_ready && (cnt == LAST_CNT);
        end else begin
          dc_gnt    = first;
          dc_rvalid = mem_ready && !is_write;
          dc_wready = mem_ready && is_write;
          dc_done   = mem_ready && (cnt == LAST_CNT);
        end
        if (mem_ready && (cnt == LAST_CNT)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (BURST_LEN 4 and 1).
module tb_mem_arbiter;

  localparam logic [31:0] KEY = 32'h5A5A_0F0F;
  localparam logic [31:0] WD  = 32'hD000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, ic_gnt, ic_rvalid, ic_done;
  logic [31:0] ic_addr, ic_rdata;
  logic        dc_req, dc_we, dc_gnt, dc_wready, dc_rvalid, dc_done;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        ic_req_1, ic_gnt_1, ic_rvalid_1, ic_done_1;
  logic [31:0] ic_addr_1, ic_rdata_1;
  logic        dc_gnt_1, dc_wready_1, dc_rvalid_1, dc_done_1;
  logic [31:0] dc_rdata_1;
  logic        mem_req_1, mem_we_1, mem_ready_1;
  logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: read data is a keyed function of the beat address.
  assign mem_rdata   = mem_addr ^ KEY;
  assign mem_rdata_1 = mem_addr_1 ^ KEY;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_wready(dc_wready), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(1)) u_dut_1 (
    .clk(clk), .rst(rst),
    .ic_req(ic_req_1), .ic_addr(ic_addr_1), .ic_gnt(ic_gnt_1), .ic_rvalid(ic_rvalid_1),
    .ic_rdata(ic_rdata_1), .ic_done(ic_done_1),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(32'h0), .dc_wdata(32'h0),
    .dc_gnt(dc_gnt_1), .dc_wready(dc_wready_1), .dc_rvalid(dc_rvalid_1),
    .dc_rdata(dc_rdata_1), .dc_done(dc_done_1),
    .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_ready(mem_ready_1), .mem_rdata(mem_rdata_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle between bursts: the port must be quiet.
  task automatic idle();
    cyc();
    #1;
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_gnt", 32'({ic_gnt, dc_gnt}), 32'd0);
  endtask

  // Full read burst with mem_ready held high; drops the owner's req after beat drop_at.
  task automatic burst_rd(input logic is_d, input logic [31:0] base, input int drop_at);
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ready = 1'b1;
      #1;
      check("rd_mem_req", 32'(mem_req), 32'd1);
      check("rd_mem_we", 32'(mem_we), 32'd0);
      check("rd_mem_addr", mem_addr, base + 32'(4 * k));
      check("rd_gnt", 32'(is_d ? dc_gnt : ic_gnt), 32'(k == 0));
      check("rd_rvalid", 32'(is_d ? dc_rvalid : ic_rvalid), 32'd1);
      check("rd_rdata", is_d ? dc_rdata : ic_rdata, (base + 32'(4 * k)) ^ KEY);
      check("rd_done", 32'(is_d ? dc_done : ic_done), 32'(k == 3));
      check("rd_other", is_d ? 32'({ic_gnt, ic_rvalid, ic_done})
                             : 32'({dc_gnt, dc_rvalid, dc_wready, dc_done}), 32'd0);
      check("rd_wready", 32'(dc_wready), 32'd0);
      if (k == drop_at) begin
        if (is_d) dc_req = 1'b0;
        else      ic_req = 1'b0;
      end
    end
  endtask

  initial begin
    int beat;
    int pulses;
    logic exp_rdy;
    rst = 1'b1;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 1'b0;
    ic_req_1 = 1'b0; ic_addr_1 = '0; mem_ready_1 = 1'b0;

    // Reset state.
    cyc();
    cyc();
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ctrl", 32'({ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_wready, dc_rvalid, dc_done}), 32'd0);
    check("rst_mem_req_1", 32'(mem_req_1), 32'd0);
    rst = 1'b0;

    // Single D refill from an unaligned address.
    dc_req = 1'b1; dc_addr = 32'h104; mem_ready = 1'b1;
    burst_rd(1'b1, 32'h100, 3);
    idle();

    // Tie after reset: D first, then strict alternation.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ic_req = 1'b1; ic_addr = 32'h44;
    dc_req = 1'b1; dc_addr = 32'h88;
    burst_rd(1'b1, 32'h80, -1);
    idle();
    burst_rd(1'b0, 32'h40, -1);
    idle();
    burst_rd(1'b1, 32'h80, -1);
    idle();
    burst_rd(1'b0, 32'h40, -1);
    ic_req = 1'b0; dc_req = 1'b0;
    idle();

    // D write-back with mem_ready toggling 1,0,1,0...
    beat = 0; pulses = 0;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2000; dc_wdata = WD;
    for (int i = 0; i < 7; i++) begin
      cyc();
      exp_rdy = (i % 2 == 0);
      mem_ready = exp_rdy;
      #1;
      check("wb_mem_req", 32'(mem_req), 32'd1);
      check("wb_mem_we", 32'(mem_we), 32'd1);
      check("wb_mem_addr", mem_addr, 32'h2000 + 32'(4 * beat));
      check("wb_mem_wdata", mem_wdata, WD + 32'(beat));
      check("wb_wready", 32'(dc_wready), 32'(exp_rdy));
      check("wb_gnt", 32'(dc_gnt), 32'(i == 0));
      check("wb_done", 32'(dc_done), 32'(i == 6));
      check("wb_rvalid", 32'({dc_rvalid, ic_rvalid}), 32'd0);
      if (dc_wready) pulses++;
      if (exp_rdy) begin
        beat++;
        dc_wdata = WD + 32'(beat);
      end
      if (i == 6) begin
        dc_req = 1'b0; dc_we = 1'b0;
      end
    end
    check("wb_pulses", 32'(pulses), 32'd4);
    mem_ready = 1'b1;
    idle();

    // Reset during the second beat of an I burst.
    ic_req = 1'b1; ic_addr = 32'h30C;
    cyc();
    #1;
    check("ab_gnt", 32'(ic_gnt), 32'd1);
    check("ab_addr0", mem_addr, 32'h300);
    cyc();
    rst = 1'b1;
    #1;
    check("ab_addr1", mem_addr, 32'h304);
    check("ab_done_beat1", 32'(ic_done), 32'd0);
    cyc();
    rst = 1'b0; ic_req = 1'b0;
    #1;
    check("ab_mem_req", 32'(mem_req), 32'd0);
    check("ab_no_done", 32'({ic_done, ic_rvalid}), 32'd0);
    ic_req = 1'b1; ic_addr = 32'h700;
    dc_req = 1'b1; dc_addr = 32'h600;
    burst_rd(1'b1, 32'h600, 3);
    idle();
    burst_rd(1'b0, 32'h700, 3);
    idle();

    // Single-beat bursts: gnt, rvalid and done together.
    ic_req_1 = 1'b1; ic_addr_1 = 32'h7; mem_ready_1 = 1'b1;
    cyc();
    #1;
    check("bl1_mem_req", 32'(mem_req_1), 32'd1);
    check("bl1_addr", mem_addr_1, 32'h4);
    check("bl1_gnt", 32'(ic_gnt_1), 32'd1);
    check("bl1_rvalid", 32'(ic_rvalid_1), 32'd1);
    check("bl1_done", 32'(ic_done_1), 32'd1);
    check("bl1_rdata", ic_rdata_1, 32'h4 ^ KEY);
    ic_req_1 = 1'b0;
    cyc();
    #1;
    check("bl1_idle", 32'(mem_req_1), 32'd0);

    // D request dropped mid-burst still runs to completion.
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h500;
    burst_rd(1'b1, 32'h500, 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
